// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, data width, line levels.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;              // wide enough for 0..DATA_W-1 and stop-bit count

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;      // also the idle line level

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_POP    = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_START  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_PARITY = 3'd5;
    localparam state_t ST_STOP   = 3'd6;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLK_DIV-1 while run_i is high and flags the last cycle of each bit.
// Latency: bit_end_o is combinational from the counter; the counter updates on the next clk.
// Backpressure: none; clear_i wins over run_i and returns the count to 0.
// Ports: clk, rst_n (async active-low); clear_i zeroes the count, run_i advances it;
//        bit_end_o is high on the final cycle of a bit period.
module uart_baud_cnt #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = run_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            // Wrap at the end of each bit so multi-bit states (DATA, STOP) keep counting.
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that drains an sfifo: pops a byte when idle and serialises it LSB first.
// Latency: tx falls 3 clk after the IDLE pop condition is sampled (POP, LOAD, START).
// Backpressure: pops only when tx_en_i && !fifo_empty_i at IDLE or the final stop cycle; a started frame always completes.
// Ports: clk, rst_n (async active-low); tx_en_i gates new pops; fifo_empty_i / fifo_data_i / fifo_rd_o
//        connect to the sfifo (registered read: data valid the cycle after fifo_rd_o);
//        tx_o serial line (idle high, registered); busy_o high outside IDLE; tx_done_o pulses on the last stop cycle.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rd_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;     // data bit index in DATA, stop bit index in STOP
    logic               tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic bit_end;
    logic baud_run;
    logic baud_clear;

    assign baud_run   = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);
    // Every state change restarts the bit period from zero.
    assign baud_clear = (state_d != state_q);

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (baud_clear),
        .run_i     (baud_run),
        .bit_end_o (bit_end)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= STOP_LVL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_en_i && !fifo_empty_i) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // sfifo read is registered: data from the POP strobe is valid now.
                shreg_d  = fifo_data_i;
`ifdef UART_TX_PARITY_EN
                parity_d = even_parity(fifo_data_i);
`endif
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        // Chain straight into the next pop to keep the inter-frame gap at two clk.
                        state_d = (tx_en_i && !fifo_empty_i) ? ST_POP : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. tx is computed from the next state so the register presents
    // the right level in the first cycle of each state.
    always_comb begin
        fifo_rd_o = (state_q == ST_POP);
        busy_o    = (state_q != ST_IDLE);
        tx_done_o = (state_q == ST_STOP) && bit_end && (idx_q == LAST_STOP);
        case (state_d)
            ST_START: tx_d = START_LVL;
            ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = STOP_LVL;
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
module tb_uart_tx_drain;

    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT 1: one stop bit, fed by a small FIFO model.
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    // DUT 2: two stop bits, fed by a constant non-empty source.
    logic       tx_en2;
    logic       fifo2_empty;
    logic [7:0] fifo2_data;
    logic       fifo2_rd, tx2, busy2, tx_done2;

    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr = 4'd0;
    int pops = 0, pops2 = 0, underflow = 0;
    int n_tests = 0, n_fail = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    uart_tx_drain #(.CLK_DIV(CD), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_rd_o(fifo_rd), .tx_o(tx), .busy_o(busy), .tx_done_o(tx_done)
    );

    uart_tx_drain #(.CLK_DIV(CD), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_en_i(tx_en2), .fifo_empty_i(fifo2_empty),
        .fifo_data_i(fifo2_data), .fifo_rd_o(fifo2_rd), .tx_o(tx2), .busy_o(busy2), .tx_done_o(tx_done2)
    );

    // Registered-read FIFO model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fifo_empty) underflow <= underflow + 1;
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
            pops      <= pops + 1;
        end
        if (fifo2_rd) pops2 <= pops2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Checks that nothing happens on the chosen DUT for a number of cycles.
    task automatic idle_window(input int sel, input int cycles, input string tag);
        int p0, tx_lo, busy_hi;
        p0 = sel ? pops2 : pops;
        tx_lo = 0;
        busy_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!(sel ? tx2 : tx)) tx_lo++;
            if (sel ? busy2 : busy) busy_hi++;
        end
        check({tag, "_pops"}, (sel ? pops2 : pops) - p0, 0);
        check({tag, "_tx_low_cycles"}, tx_lo, 0);
        check({tag, "_busy_cycles"}, busy_hi, 0);
    endtask

    // Waits for a pop, then checks the whole frame cycle by cycle.
    task automatic frame(input int sel, input logic [7:0] b, input int drop_at, input string tag);
        int n, nb, cyc, done_cnt, busy_lo;
        logic got, last_done, d;
        logic exp_bits [0:11];
        logic [3:0] samp;
        n = 0;
        got = 1'b0;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clk);
            n = i;
            got = sel ? fifo2_rd : fifo_rd;
        end
        check({tag, "_pop_seen"}, got, 1);
        if (!got) return;
        check({tag, "_pop_latency"}, n, 1);
        @(negedge clk);
        check({tag, "_load_rd"}, sel ? fifo2_rd : fifo_rd, 0);
        check({tag, "_load_tx"}, sel ? tx2 : tx, 1);
        nb = 0;
        exp_bits[nb++] = 1'b0;
        for (int j = 0; j < 8; j++) exp_bits[nb++] = b[j];
        if (PAR == 1) exp_bits[nb++] = ^b;
        for (int s = 0; s < (sel ? 2 : 1); s++) exp_bits[nb++] = 1'b1;
        cyc = 0;
        done_cnt = 0;
        busy_lo = 0;
        last_done = 1'b0;
        for (int k = 0; k < nb; k++) begin
            samp = 4'h0;
            for (int c = 0; c < CD; c++) begin
                @(negedge clk);
                if (cyc == drop_at) tx_en2 = 1'b0;
                cyc++;
                samp[c] = sel ? tx2 : tx;
                d = sel ? tx_done2 : tx_done;
                if (d) done_cnt++;
                last_done = d;
                if (!(sel ? busy2 : busy)) busy_lo++;
            end
            check($sformatf("%s_bit%0d", tag, k), samp, {4{exp_bits[k]}});
        end
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_on_last"}, last_done, 1);
        check({tag, "_busy_low_cycles"}, busy_lo, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_en2 = 1'b0;
        fifo2_empty = 1'b1;
        fifo2_data = 8'h3C;
        wr_ptr = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx2", tx2, 1);
        check("rst_busy2", busy2, 0);
        rst_n = 1'b1;

        // Empty FIFO with tx enabled: nothing moves.
        tx_en = 1'b1;
        idle_window(0, 100, "empty");

        // Data present but tx disabled: no pop until enabled.
        tx_en = 1'b0;
        push(8'hA5);
        idle_window(0, 20, "gated");
        tx_en = 1'b1;
        frame(0, 8'hA5, -1, "a5");
        @(negedge clk);
        check("a5_after_busy", busy, 0);
        check("a5_after_tx", tx, 1);
        check("a5_pop_total", pops, 1);

        // Back-to-back frames: each pop lands the cycle after the previous tx_done.
        push(8'h00);
        push(8'hFF);
        push(8'h07);
        frame(0, 8'h00, -1, "b2b_00");
        frame(0, 8'hFF, -1, "b2b_ff");
        frame(0, 8'h07, -1, "b2b_07");
        @(negedge clk);
        check("b2b_after_busy", busy, 0);
        check("b2b_pop_total", pops, 4);

        // Asynchronous reset in the middle of DATA.
        push(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = fifo_rd;
        end
        check("midrst_pop_seen", seen, 1);
        repeat (13) @(negedge clk);
        check("midrst_pre_tx", tx, 0);
        check("midrst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_fifo_rd", fifo_rd, 0);
        check("midrst_tx_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_window(0, 20, "post_rst");
        push(8'h5A);
        frame(0, 8'h5A, -1, "post_rst_5a");

        // Two stop bits, tx_en dropped during DATA: frame completes then stays idle.
        fifo2_empty = 1'b0;
        tx_en2 = 1'b1;
        frame(1, 8'h3C, 10, "stop2");
        idle_window(1, 20, "stop2_idle");
        check("stop2_pop_total", pops2, 1);

        check("no_underflow", underflow, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
